fft_frame_ctrl: RTL and testbench



---
 rtl/fft_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Frame sequencer for a parallel N-point FFT datapath. Serial real samples are
// collected into an input frame buffer that drives the FFT's packed input bus.
// When the frame is complete a one-cycle fft_start is issued. After FFT_LAT
// edges the N complex bins are captured into an output buffer and streamed out
// one bin per handshake.
//
// Handshakes (both streams): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds data stable while valid is
// high and ready is low. Neither valid depends combinationally on its ready.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_valid/s_ready   input sample stream, s_data = real sample
//   fft_start         one-cycle start pulse to the FFT datapath
//   fft_data_in       packed frame, sample k at [(N-k)*WIDTH-1 -: WIDTH]
//   fft_out_real/imag FFT bins, bin i at [(N-i)*WIDTH-1 -: WIDTH]
//   m_valid/m_ready   output bin stream: m_real, m_imag, m_index, m_last
//   busy              any sample or frame in flight
//   frame_cnt         frames fully drained, wraps at 2^16
// -----------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter int N       = 32,
    parameter int WIDTH   = 16,
    parameter int FFT_LAT = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   s_ready,
    output logic                   fft_start,
    output logic [N*WIDTH-1:0]     fft_data_in,
    input  logic [N*WIDTH-1:0]     fft_out_real,
    input  logic [N*WIDTH-1:0]     fft_out_imag,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_real,
    output logic [WIDTH-1:0]       m_imag,
    output logic [$clog2(N)-1:0]   m_index,
    output logic                   m_last,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int IW = $clog2(N);
    localparam int LW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;
    localparam logic [IW:0]   FILL_FULL = (IW+1)'(N);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [LW-1:0] LAT_INIT  = LW'(FFT_LAT - 1);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_HOLD} cstate_t;
    typedef enum logic       {O_EMPTY, O_DRAIN}       ostate_t;

    logic [IW:0]      r_fill_cnt;
    logic [WIDTH-1:0] r_in_buf  [N];
    logic [WIDTH-1:0] r_out_re  [N];
    logic [WIDTH-1:0] r_out_im  [N];
    cstate_t          r_cstate;
    ostate_t          r_ostate;
    logic [LW-1:0]    r_lat_cnt;
    logic [IW-1:0]    r_idx;
    logic [15:0]      r_frame_cnt;

    logic w_s_ready;
    logic w_accept;
    logic w_start;
    logic w_capture;
    logic w_hs;
    logic w_hs_last;

    assign w_s_ready = (r_fill_cnt < FILL_FULL);
    assign w_accept  = s_valid && w_s_ready;
    // Start is decoded from registered state only, so it is high for exactly
    // the one cycle between "frame full" and the edge that clears fill_cnt.
    assign w_start   = (r_cstate == C_IDLE) && (r_fill_cnt == FILL_FULL);
    // Capture only into an empty output buffer; the FFT outputs stay valid
    // while parked in C_HOLD because no new start is issued outside C_IDLE.
    assign w_capture = (r_ostate == O_EMPTY) &&
                       (((r_cstate == C_WAIT) && (r_lat_cnt == '0)) ||
                        (r_cstate == C_HOLD));
    assign w_hs      = (r_ostate == O_DRAIN) && m_ready;
    assign w_hs_last = w_hs && (r_idx == IDX_LAST);

    // ---------------------------------------------------------------- fill
    // The FFT registers its input on the start edge, so the buffer may be
    // refilled from the very next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_in_buf[i] <= '0;
            end
        end else if (w_start) begin
            r_fill_cnt <= '0;
        end else if (w_accept) begin
            r_in_buf[r_fill_cnt[IW-1:0]] <= s_data;
            r_fill_cnt <= r_fill_cnt + (IW+1)'(1);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign fft_data_in[(N-k)*WIDTH-1 -: WIDTH] = r_in_buf[k];
    end

    // ------------------------------------------------------- compute FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cstate  <= C_IDLE;
            r_lat_cnt <= '0;
        end else begin
            case (r_cstate)
                C_IDLE: begin
                    if (w_start) begin
                        r_cstate  <= C_WAIT;
                        r_lat_cnt <= LAT_INIT;
                    end
                end
                C_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_cstate <= (r_ostate == O_EMPTY) ? C_IDLE : C_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end
                end
                C_HOLD: begin
                    if (r_ostate == O_EMPTY) begin
                        r_cstate <= C_IDLE;
                    end
                end
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------- output FSM
    // Capture only happens in O_EMPTY and handshakes only in O_DRAIN, so the
    // two branches below are mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ostate    <= O_EMPTY;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_out_re[i] <= '0;
                r_out_im[i] <= '0;
            end
        end else begin
            case (r_ostate)
                O_EMPTY: begin
                    if (w_capture) begin
                        for (int i = 0; i < N; i++) begin
                            r_out_re[i] <= fft_out_real[(N-i)*WIDTH-1 -: WIDTH];
                            r_out_im[i] <= fft_out_imag[(N-i)*WIDTH-1 -: WIDTH];
                        end
                        r_idx    <= '0;
                        r_ostate <= O_DRAIN;
                    end
                end
                O_DRAIN: begin
                    if (w_hs_last) begin
                        // idx stays at N-1 so the last bin remains visible.
                        r_ostate    <= O_EMPTY;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end else if (w_hs) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: r_ostate <= O_EMPTY;
            endcase
        end
    end

    // ----------------------------------------------------------- outputs
    // Data outputs read the output buffer at idx; since neither changes in
    // O_EMPTY, the last bin's values hold after the frame drains.
    assign s_ready   = w_s_ready;
    assign fft_start = w_start;
    assign m_valid   = (r_ostate == O_DRAIN);
    assign m_real    = r_out_re[r_idx];
    assign m_imag    = r_out_im[r_idx];
    assign m_index   = r_idx;
    assign m_last    = (r_ostate == O_DRAIN) && (r_idx == IDX_LAST);
    assign busy      = (r_fill_cnt != '0) || (r_cstate != C_IDLE) ||
                       (r_ostate != O_EMPTY);
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Bench for fft_frame_ctrl with an FFT stub (FFT_LAT-edge register delay,
// real bin i = x(i), imag bin i = ~x(i)). A negedge monitor keeps a frame-level
// model: accepted samples accumulate into frames, complete frames wait for a
// start, started frames become an expected bin queue drained by handshakes.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

  localparam int N   = 32;
  localparam int W   = 16;
  localparam int LAT = 6;
  localparam int BW  = N * W;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------------- DUT
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready;
  logic          fft_start;
  logic [BW-1:0] fft_data_in;
  logic [BW-1:0] fft_out_real;
  logic [BW-1:0] fft_out_imag;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_real;
  logic [W-1:0]  m_imag;
  logic [4:0]    m_index;
  logic          m_last;
  logic          busy;
  logic [15:0]   frame_cnt;

  fft_frame_ctrl #(.N(N), .WIDTH(W), .FFT_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .fft_start    (fft_start),
    .fft_data_in  (fft_data_in),
    .fft_out_real (fft_out_real),
    .fft_out_imag (fft_out_imag),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_real       (m_real),
    .m_imag       (m_imag),
    .m_index      (m_index),
    .m_last       (m_last),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  // FFT stub: input registered on the start edge, visible at the output
  // after LAT edges; older contents are visible before that.
  logic [BW-1:0] stub_st [LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stub_st[i] <= '0;
    end else begin
      if (fft_start) stub_st[0] <= fft_data_in;
      for (int i = 1; i < LAT; i++) stub_st[i] <= stub_st[i-1];
    end
  end
  assign fft_out_real = stub_st[LAT-1];
  assign fft_out_imag = ~stub_st[LAT-1];

  // m_ready driver: fixed value or random per cycle
  int   mr_mode = 0;
  logic mr_val = 1'b1;
  always begin
    @(posedge clk);
    #1;
    m_ready = (mr_mode != 0) ? 1'($urandom_range(0, 1)) : mr_val;
  end

  // ------------------------------------------------------------ scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [W-1:0]  part_q[$];
  logic [BW-1:0] pend_q[$];
  logic [W-1:0]  exp_q[$];
  int            out_idx = 0;
  int            frames_done = 0;
  int            n_starts = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [W-1:0]  prev_real, prev_imag;
  logic [4:0]    prev_index;

  int            last_acc_cyc = 0, start_cyc = 0, rise_cyc = 0;
  logic [W-1:0]  start_top = '0;
  logic [W-1:0]  first_real = '0, first_imag = '0, last_real = '0;

  always @(negedge clk) begin
    logic [BW-1:0] frame;
    logic [W-1:0]  e_im;
    if (!rst_n) begin
      part_q.delete();
      pend_q.delete();
      exp_q.delete();
      out_idx = 0;
      frames_done = 0;
      n_starts = 0;
      prev_valid = 1'b0;
    end else begin
      check("s_ready", {{(BW-1){1'b0}}, s_ready}, BW'(pend_q.size() == 0));
      check("busy", {{(BW-1){1'b0}}, busy},
            BW'(part_q.size() != 0 || pend_q.size() != 0 || exp_q.size() != 0));
      check("frame_cnt", BW'(frame_cnt), BW'(16'(frames_done)));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("m_valid_idle", BW'(m_valid), BW'(0));
        end else begin
          e_im = ~exp_q[0];
          check("m_real", BW'(m_real), BW'(exp_q[0]));
          check("m_imag", BW'(m_imag), BW'(e_im));
          check("m_index", BW'(m_index), BW'(out_idx));
          check("m_last", BW'(m_last), BW'(out_idx == N-1));
        end
        if (prev_valid && !prev_ready) begin
          check("hold_real", BW'(m_real), BW'(prev_real));
          check("hold_imag", BW'(m_imag), BW'(prev_imag));
          check("hold_index", BW'(m_index), BW'(prev_index));
        end
        if (!prev_valid) begin
          rise_cyc = cyc;
          first_real = m_real;
          first_imag = m_imag;
        end
        if (m_last) last_real = m_real;
      end else begin
        check("m_last_idle", BW'(m_last), BW'(0));
      end

      // events that take effect on the coming edge
      if (fft_start) begin
        if (pend_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL fft_start: got a pulse with no complete frame, expected none (cycle %0d)", cyc);
        end else begin
          check("fft_data_in", fft_data_in, pend_q[0]);
          frame = pend_q.pop_front();
          for (int k = 0; k < N; k++) exp_q.push_back(frame[(N-k)*W-1 -: W]);
          n_starts++;
          start_cyc = cyc;
          start_top = fft_data_in[BW-1 -: W];
        end
      end
      if (s_valid && s_ready) begin
        part_q.push_back(s_data);
        last_acc_cyc = cyc;
        if (part_q.size() == N) begin
          for (int k = 0; k < N; k++) frame[(N-k)*W-1 -: W] = part_q[k];
          pend_q.push_back(frame);
          part_q.delete();
        end
      end
      if (m_valid && m_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (out_idx == N-1) begin
          out_idx = 0;
          frames_done++;
        end else begin
          out_idx++;
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_real  = m_real;
      prev_imag  = m_imag;
      prev_index = m_index;
    end
  end

  // ----------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_sample(input logic [W-1:0] d, input int gap);
    logic ok;
    int   t;
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = s_ready;
      tick();
      t++;
      if (!ok && t > 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", t);
        ok = 1'b1;
      end
    end
    s_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_samples(input int cnt, input int first, input int incr,
                              input int gap);
    for (int k = 0; k < cnt; k++) begin
      if (incr != 0) send_sample(W'(first + k), gap);
      else           send_sample(W'($urandom), gap);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles, expected 0", budget);
    end
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int t;
    int s0;

    // reset values
    reset_dut(2);
    @(negedge clk);
    check("rst_fft_start", BW'(fft_start), BW'(0));
    check("rst_m_valid", BW'(m_valid), BW'(0));
    check("rst_s_ready", BW'(s_ready), BW'(1));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_frame_cnt", BW'(frame_cnt), BW'(0));
    check("rst_fft_data_in", fft_data_in, '0);
    check("rst_m_real", BW'(m_real), BW'(0));
    check("rst_m_index", BW'(m_index), BW'(0));
    check("rst_m_last", BW'(m_last), BW'(0));

    // single frame x(k)=k+1, back-to-back, m_ready=1
    tick();
    mr_mode = 0;
    mr_val  = 1'b1;
    send_samples(N, 1, 1, 0);
    wait_idle(300);
    check("start_after_last_accept", BW'(start_cyc - last_acc_cyc), BW'(1));
    check("capture_latency", BW'(rise_cyc - start_cyc), BW'(LAT + 1));
    check("fft_data_in_x0", BW'(start_top), BW'(16'h0001));
    check("first_bin_real", BW'(first_real), BW'(16'h0001));
    check("first_bin_imag", BW'(first_imag), BW'(16'hFFFE));
    check("last_bin_real", BW'(last_real), BW'(16'h0020));
    check("single_frame_cnt", BW'(frame_cnt), BW'(1));
    check("single_starts", BW'(n_starts), BW'(1));

    // backpressure: three frames with m_ready=0
    tick();
    reset_dut(2);
    mr_val = 1'b0;
    repeat (2) tick();
    send_samples(3 * N, 0, 0, 0);
    repeat (10) tick();
    @(negedge clk);
    check("bp_s_ready", BW'(s_ready), BW'(0));
    check("bp_m_valid", BW'(m_valid), BW'(1));
    check("bp_m_index", BW'(m_index), BW'(0));
    check("bp_starts", BW'(n_starts), BW'(2));
    tick();
    mr_val = 1'b1;
    wait_idle(600);
    check("bp_frame_cnt", BW'(frame_cnt), BW'(3));
    check("bp_starts_total", BW'(n_starts), BW'(3));

    // random m_ready during drain
    tick();
    mr_mode = 1;
    send_samples(3 * N, 0, 0, 0);
    wait_idle(3000);
    mr_mode = 0;
    mr_val  = 1'b1;
    check("rand_frame_cnt", BW'(frame_cnt), BW'(6));

    // sparse input: s_valid every 3rd cycle
    tick();
    s0 = n_starts;
    send_samples(2 * N, 0, 0, 2);
    wait_idle(400);
    check("sparse_starts", BW'(n_starts - s0), BW'(2));
    check("sparse_frame_cnt", BW'(frame_cnt), BW'(8));

    // reset mid-drain and mid-fill
    tick();
    mr_val = 1'b0;
    repeat (2) tick();
    send_samples(N, 0, 0, 0);
    send_samples(17, 0, 0, 0);
    mr_val = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(m_valid && m_index == 5'd10) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("reach_index_10", BW'(m_index), BW'(10));
    tick();
    reset_dut(1);
    @(negedge clk);
    check("mid_rst_m_valid", BW'(m_valid), BW'(0));
    check("mid_rst_busy", BW'(busy), BW'(0));
    check("mid_rst_s_ready", BW'(s_ready), BW'(1));
    check("mid_rst_frame_cnt", BW'(frame_cnt), BW'(0));
    tick();
    send_samples(N, 100, 1, 0);
    wait_idle(300);
    check("post_rst_first_real", BW'(first_real), BW'(100));
    check("post_rst_frame_cnt", BW'(frame_cnt), BW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
